onehot_index_encoder: RTL and testbench

- Inverse of the 4-to-16 one-hot decoder.
- Accepts a 16-bit request vector and emits the 4-bit index of every set bit, one index per output handshake.
- Uses the decoder's MSB-first mapping: bit 15 is index 0 and bit 0 is index 15. Decoding the emitted index reproduces exactly one bit of the captured vector.
- Sits between request-collecting logic and any consumer of 4-bit indices, such as the register and rotator datapath.

---
 rtl/onehot_pkg.sv | 12 +
 rtl/onehot_index_encoder_priority_index.sv | 29 ++
 rtl/onehot_index_encoder.sv | 87 ++++++++
 tb/tb_onehot_index_encoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared constants and state encoding for the one-hot decoder/encoder pair.
package onehot_pkg;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_index_encoder_priority_index.sv
// Combinational priority pick: highest set bit of vec, reported MSB-first
// (bit WIDTH-1 is index 0), plus any/single set-bit flags.
module priority_index
  import onehot_pkg::*;
#(
  parameter int WIDTH = onehot_pkg::WIDTH,
  parameter int IDX_W = onehot_pkg::IDX_W
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any_set,
  output logic             single_set
);

  // Ascending scan so the highest set bit overrides lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(WIDTH - 1 - i);
    end
  end

  // x & (x-1) drops the lowest set bit; zero result means at most one bit.
  always_comb begin
    any_set    = |vec;
    single_set = any_set && ((vec & (vec - 1'b1)) == '0);
  end

endmodule

// File: rtl/onehot_index_encoder.sv
// Captures a request vector and drains it one MSB-first index per handshake.
module onehot_index_encoder
  import onehot_pkg::*;
#(
  parameter int WIDTH = onehot_pkg::WIDTH,
  parameter int IDX_W = onehot_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pending, pending_nxt;
  logic             zero_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any, pick_single;
  logic [WIDTH-1:0] clr_mask;

  priority_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pick (
    .vec        (pending),
    .idx        (pick_idx),
    .any_set    (pick_any),
    .single_set (pick_single)
  );

  // Outputs depend only on registered state; pending is zero in IDLE so
  // out_idx/out_last naturally rest at 0.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DRAIN);
    out_idx   = pick_idx;
    out_last  = (state == DRAIN) && pick_single;
  end

  // One-hot mask of the bit currently being emitted.
  always_comb begin
    clr_mask = {{(WIDTH-1){1'b0}}, 1'b1} << (IDX_W'(WIDTH - 1) - pick_idx);
  end

  // Next-state: capture in IDLE, clear one bit per accepted transfer in DRAIN.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    zero_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_nxt = in_vec;
            state_nxt   = DRAIN;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pending_nxt = pending & ~clr_mask;
          if (pick_single || !pick_any) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with asynchronous reset discarding any pending bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      zero_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      zero_err <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_index_encoder.sv
// Directed bench for onehot_index_encoder with hand-computed expectations.
module tb_onehot_index_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        zero_err;

  int vectors = 0;
  int miscompares = 0;

  onehot_index_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {in_ready, out_valid, out_idx, out_last, zero_err} for compact checks.
  function automatic logic [31:0] outs();
    return {24'd0, in_ready, out_valid, out_idx, out_last, zero_err};
  endfunction

  function automatic logic [31:0] exp_outs(input logic rdy, input logic vld,
                                           input logic [3:0] idx, input logic last,
                                           input logic zerr);
    return {24'd0, rdy, vld, idx, last, zerr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    #2;
    check("reset_state", outs(), exp_outs(1, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    step();
    check("idle_after_reset", outs(), exp_outs(1, 0, 0, 0, 0));

    // Single bit 8000 -> idx 0, last.
    in_valid = 1'b1; in_vec = 16'h8000;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    check("v8000_idx0", outs(), exp_outs(0, 1, 4'd0, 1, 0));
    step();
    check("v8000_back_idle", outs(), exp_outs(1, 0, 0, 0, 0));

    // A001 -> 0, 2, 15.
    in_valid = 1'b1; in_vec = 16'hA001;
    step();
    in_valid = 1'b0;
    check("vA001_idx0", outs(), exp_outs(0, 1, 4'd0, 0, 0));
    step();
    check("vA001_idx2", outs(), exp_outs(0, 1, 4'd2, 0, 0));
    step();
    check("vA001_idx15", outs(), exp_outs(0, 1, 4'd15, 1, 0));
    step();
    check("vA001_idle", outs(), exp_outs(1, 0, 0, 0, 0));

    // 0F00 with a 3-cycle stall.
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 16'h0F00;
    step();
    in_valid = 1'b0; in_vec = 16'hFFFF;  // ignored while draining
    check("v0F00_stall1", outs(), exp_outs(0, 1, 4'd4, 0, 0));
    in_valid = 1'b1;
    step();
    check("v0F00_stall2", outs(), exp_outs(0, 1, 4'd4, 0, 0));
    step();
    in_valid = 1'b0;
    check("v0F00_stall3", outs(), exp_outs(0, 1, 4'd4, 0, 0));
    out_ready = 1'b1;
    step();
    check("v0F00_idx5", outs(), exp_outs(0, 1, 4'd5, 0, 0));
    step();
    check("v0F00_idx6", outs(), exp_outs(0, 1, 4'd6, 0, 0));
    step();
    check("v0F00_idx7", outs(), exp_outs(0, 1, 4'd7, 1, 0));
    step();
    check("v0F00_idle", outs(), exp_outs(1, 0, 0, 0, 0));

    // All-zero vector.
    in_valid = 1'b1; in_vec = 16'h0000;
    step();
    in_valid = 1'b0;
    check("zero_pulse", outs(), exp_outs(1, 0, 0, 0, 1));
    step();
    check("zero_pulse_end", outs(), exp_outs(1, 0, 0, 0, 0));

    // FFFF, reset after the 5th transfer.
    in_valid = 1'b1; in_vec = 16'hFFFF;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("vFFFF_seq", outs(), exp_outs(0, 1, 4'(k), 0, 0));
      step();
    end
    check("vFFFF_idx5", outs(), exp_outs(0, 1, 4'd5, 0, 0));
    rst = 1'b1;
    #1;
    check("async_reset", outs(), exp_outs(1, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_reset_quiet", outs(), exp_outs(1, 0, 0, 0, 0));
    end
    in_valid = 1'b1; in_vec = 16'h0001;
    step();
    in_valid = 1'b0;
    check("v0001_idx15", outs(), exp_outs(0, 1, 4'd15, 1, 0));
    step();
    check("v0001_idle", outs(), exp_outs(1, 0, 0, 0, 0));

    // Round trip over every decoder output.
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_vec = 16'h8000 >> k;
      step();
      in_valid = 1'b0;
      check("roundtrip", outs(), exp_outs(0, 1, 4'(k), 1, 0));
      step();
      check("roundtrip_idle", outs(), exp_outs(1, 0, 0, 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
